// File: rtl/stack_pkg.sv
// Shared helpers for the multi-pop register stack (stack_multi).
// Holds the port-width helpers, the error-flag record and a parameter
// legality function. Top and cell both import this package.
package stack_pkg;

    // Width of the pop_n port. It must be able to encode 0..POP_MAX.
    function automatic int pop_w(input int pop_max);
        return $clog2(pop_max + 1);
    endfunction

    // Width of the occupancy counter. It must be able to encode 0..DEPTH.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Overflow/underflow flag pair, kept together in one register.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } stack_err_t;

    // Returns 1 when the parameter set is legal. The top module checks
    // this at elaboration time.
    function automatic bit params_ok(input int depth, input int visibles, input int pop_max);
        return (depth >= 2) && (visibles >= 1) && (visibles <= depth) &&
               (pop_max >= 1) && (pop_max <= depth);
    endfunction

endpackage

// File: rtl/stack_multi_cell.sv
// One entry of stack_multi.
// On each enabled edge the entry loads one of its neighbours from the
// candidate window data[i-1 .. i+POP_MAX]. The top entry loads insert
// instead when push is set.
module stack_multi_cell
    import stack_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               POP_MAX = 2,
    parameter int               PW      = 2,
    parameter logic [WIDTH-1:0] BOTTOM  = '0,
    parameter bit               IS_TOP  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] insert,
    input  logic [WIDTH-1:0] cand [POP_MAX+2],
    input  logic             push,
    input  logic [PW-1:0]    pop_n,
    input  logic             enable,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_nxt;
    int               sel;

    // Select the source for this entry: cand[K] on push, cand[K+1] otherwise.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        data_nxt = data;
        sel      = push ? int'(pop_n) : int'(pop_n) + 1;
        for (int j = 0; j < POP_MAX + 2; j++) begin
            if (j == sel) data_nxt = cand[j];
        end
        if (IS_TOP && push) data_nxt = insert;
    end

    // Entry register. It clears to BOTTOM asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: each entry is a discrete flop with its own reset. This is not a RAM, so resetting it is legitimate.
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignment, so all entries update from the same pre-edge values.
            data <= BOTTOM;
        end else if (enable) begin
            data <= data_nxt;
        end
    end

endmodule

// File: rtl/stack_multi.sv
// stack_multi: register stack that pushes one entry and pops up to POP_MAX
// entries per cycle. It tracks occupancy and flags overflow/underflow.
// Optional build macro STACK_ERR_STICKY_EN makes the error flags sticky
// and adds the err_clr port. The default build gives one-cycle pulses.
module stack_multi
    import stack_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 8,
    parameter int               VISIBLES = 2,
    parameter int               POP_MAX  = 2,
    parameter logic [WIDTH-1:0] BOTTOM   = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             push,
    input  logic [pop_w(POP_MAX)-1:0]        pop_n,
    input  logic [WIDTH-1:0]                 insert,
`ifdef STACK_ERR_STICKY_EN
    input  logic                             err_clr,
`endif
    output logic [VISIBLES-1:0][WIDTH-1:0]   tops,
    output logic [cnt_w(DEPTH)-1:0]          count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PW = pop_w(POP_MAX);
    localparam int CW = cnt_w(DEPTH);

    // One spare bit so that count + 1 - K can neither wrap nor go negative.
    typedef logic [CW:0] cnt_ext_t;

    if (!params_ok(DEPTH, VISIBLES, POP_MAX)) begin : g_bad_params
        $error("stack_multi: need DEPTH>=2, 1<=VISIBLES<=DEPTH, 1<=POP_MAX<=DEPTH");
    end

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [CW-1:0]               count_q;
    stack_err_t                  err_q;
    stack_err_t                  err_ev;
    cnt_ext_t                    cnt_sum;
    cnt_ext_t                    cnt_nxt;
    logic                        legal_k;
    logic                        enable;

    // Decide whether this cycle's op is accepted, and compute the next occupancy.
    always_comb begin
        legal_k          = int'(pop_n) <= POP_MAX;
        err_ev.underflow = legal_k && (cnt_ext_t'(pop_n) > cnt_ext_t'(count_q));
        enable           = legal_k && !err_ev.underflow;
        cnt_sum          = cnt_ext_t'(count_q) + cnt_ext_t'(push) - cnt_ext_t'(pop_n);
        err_ev.overflow  = enable && (cnt_sum > cnt_ext_t'(DEPTH));
        cnt_nxt          = err_ev.overflow ? cnt_ext_t'(DEPTH) : cnt_sum;
    end

    // The occupancy counter only moves on accepted ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= cnt_nxt[CW-1:0];
        end
    end

    // Error flags: sticky until cleared, or one-cycle pulses, depending on the build.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
`ifdef STACK_ERR_STICKY_EN
            err_q.overflow  <= err_ev.overflow  || (err_q.overflow  && !err_clr);
            err_q.underflow <= err_ev.underflow || (err_q.underflow && !err_clr);
`else
            err_q <= err_ev;
`endif
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [WIDTH-1:0] cand [POP_MAX+2];
        // Window data[i-1 .. i+POP_MAX]. Positions outside the stack read BOTTOM.
        for (genvar j = 0; j < POP_MAX + 2; j++) begin : g_cand
            if ((i - 1 + j < 0) || (i - 1 + j >= DEPTH)) begin : g_bot
                assign cand[j] = BOTTOM;
            end else begin : g_dat
                assign cand[j] = data[i-1+j];
            end
        end

        stack_multi_cell #(
            .WIDTH   (WIDTH),
            .POP_MAX (POP_MAX),
            .PW      (PW),
            .BOTTOM  (BOTTOM),
            .IS_TOP  (i == 0)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .insert  (insert),
            .cand    (cand),
            .push    (push),
            .pop_n   (pop_n),
            .enable  (enable),
            .data    (data[i])
        );
    end

    for (genvar v = 0; v < VISIBLES; v++) begin : g_tops
        assign tops[v] = data[v];
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

endmodule

// File: tb/tb_stack_multi.sv
// Self-checking bench for stack_multi.
// A queue-based reference model (front = top of stack) is compared against
// the DUT after every op. The bench runs directed scenarios and then random ops.
module tb_stack_multi;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int VISIBLES = 2;
    localparam int POP_MAX  = 2;
    localparam int PW       = $clog2(POP_MAX + 1);
    localparam int CW       = $clog2(DEPTH + 1);

    logic                           clk;
    logic                           reset_n;
    logic                           push;
    logic [PW-1:0]                  pop_n;
    logic [WIDTH-1:0]               insert;
`ifdef STACK_ERR_STICKY_EN
    logic                           err_clr;
`endif
    logic [VISIBLES-1:0][WIDTH-1:0] tops;
    logic [CW-1:0]                  count;
    logic                           empty;
    logic                           full;
    logic                           overflow;
    logic                           underflow;

    stack_multi #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .VISIBLES (VISIBLES),
        .POP_MAX  (POP_MAX),
        .BOTTOM   ('0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop_n     (pop_n),
        .insert    (insert),
`ifdef STACK_ERR_STICKY_EN
        .err_clr   (err_clr),
`endif
        .tops      (tops),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [WIDTH-1:0] model_q[$];
    logic             exp_ov;
    logic             exp_uf;
    int               checks;
    int               failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < VISIBLES; i++) begin
            check($sformatf("%s tops[%0d]", tag, i), 64'(tops[i]),
                  (i < model_q.size()) ? 64'(model_q[i]) : 64'(0));
        end
        check({tag, " count"},     64'(count),     64'(model_q.size()));
        check({tag, " empty"},     64'(empty),     64'(model_q.size() == 0));
        check({tag, " full"},      64'(full),      64'(model_q.size() == DEPTH));
        check({tag, " overflow"},  64'(overflow),  64'(exp_ov));
        check({tag, " underflow"}, 64'(underflow), 64'(exp_uf));
    endtask

    // Apply one op on the next edge, advance the model, then compare.
    task automatic do_op(input string tag, input logic p, input int k,
                         input logic [WIDTH-1:0] ins, input logic clr);
        logic ov_ev;
        logic uf_ev;
        @(negedge clk);
        push   = p;
        pop_n  = PW'(k);
        insert = ins;
`ifdef STACK_ERR_STICKY_EN
        err_clr = clr;
`endif
        ov_ev = 1'b0;
        uf_ev = 1'b0;
        if (k > model_q.size()) begin
            uf_ev = 1'b1;
        end else begin
            for (int n = 0; n < k; n++) model_q.delete(0);
            if (p) begin
                model_q.push_front(ins);
                if (model_q.size() > DEPTH) begin
                    model_q.delete(model_q.size() - 1);
                    ov_ev = 1'b1;
                end
            end
        end
`ifdef STACK_ERR_STICKY_EN
        exp_ov = ov_ev | (exp_ov & ~clr);
        exp_uf = uf_ev | (exp_uf & ~clr);
`else
        exp_ov = ov_ev;
        exp_uf = uf_ev;
        if (clr) exp_ov = ov_ev;
`endif
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_ov = 1'b0;
        exp_uf = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        push    = 1'b0;
        pop_n   = '0;
        insert  = '0;
`ifdef STACK_ERR_STICKY_EN
        err_clr = 1'b0;
`endif
        reset_n = 1'b0;
        #12;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-op: push three values, then assert reset between edges.
        do_op("push5", 1'b1, 0, 32'd5, 1'b0);
        do_op("push6", 1'b1, 0, 32'd6, 1'b0);
        do_op("push7", 1'b1, 0, 32'd7, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_reset");
        @(negedge clk);
        push    = 1'b0;
        pop_n   = '0;
        reset_n = 1'b1;

        // Fill to full, push once more to overflow, then drain.
        for (int v = 1; v <= DEPTH; v++) do_op($sformatf("fill%0d", v), 1'b1, 0, WIDTH'(v), 1'b0);
        do_op("overflow_push9", 1'b1, 0, 32'd9, 1'b0);
`ifdef STACK_ERR_STICKY_EN
        do_op("overflow_hold", 1'b0, 0, 32'd0, 1'b0);
        do_op("overflow_clr", 1'b0, 0, 32'd0, 1'b1);
`endif
        for (int n = 0; n < DEPTH; n++) do_op($sformatf("drain%0d", n), 1'b0, 1, 32'd0, 1'b0);

        // Binary ALU op: [3,4,10] -> pop 2 and push 7 -> [7,10].
        do_op("alu_p10", 1'b1, 0, 32'd10, 1'b0);
        do_op("alu_p4",  1'b1, 0, 32'd4,  1'b0);
        do_op("alu_p3",  1'b1, 0, 32'd3,  1'b0);
        do_op("alu_op",  1'b1, 2, 32'd7,  1'b0);

        // Replace the top: [5,6] -> push 9 with pop 1 -> [9,6].
        do_op("rep_pop2", 1'b0, 2, 32'd0, 1'b0);
        do_op("rep_p6",   1'b1, 0, 32'd6, 1'b0);
        do_op("rep_p5",   1'b1, 0, 32'd5, 1'b0);
        do_op("replace",  1'b1, 1, 32'd9, 1'b0);

        // Underflow with push: count 1, pop 2 -> nothing changes.
        do_op("uf_pop2", 1'b0, 2, 32'd0, 1'b0);
        do_op("uf_p4",   1'b1, 0, 32'd4, 1'b0);
        do_op("underflow_push", 1'b1, 2, 32'd1, 1'b0);
        do_op("uf_after", 1'b0, 0, 32'd0, 1'b0);
`ifdef STACK_ERR_STICKY_EN
        do_op("uf_clr_and_event", 1'b0, 2, 32'd0, 1'b1);
        do_op("uf_clr", 1'b0, 0, 32'd0, 1'b1);
`endif

        // Multi-pop to empty, then underflow on the empty stack.
        do_op("mp_pop1", 1'b0, 1, 32'd0, 1'b0);
        do_op("mp_p2",   1'b1, 0, 32'd2, 1'b0);
        do_op("mp_p1",   1'b1, 0, 32'd1, 1'b0);
        do_op("multi_pop_empty", 1'b0, 2, 32'd0, 1'b0);
        do_op("empty_underflow", 1'b0, 1, 32'd0, 1'b0);

        // Random ops, biased toward pushes so that full and overflow are reached.
        for (int n = 0; n < 400; n++) begin
            logic p;
            int   k;
            p = ($urandom_range(0, 9) < 6);
            k = $urandom_range(0, POP_MAX);
            do_op($sformatf("rand%0d", n), p, k, $urandom(), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
